dram_stream_loader: RTL and testbench

- Bus initiator for the memory-stage port (mwmem / malu / mb in, mmo out).
- Accepts a valid/ready word stream and writes it into data memory at word addresses 0..len-1.
- Reads the words back and compares a running checksum of written data against one of read data.
- Reports pass/fail plus word count with one store to I/O output port 0 (address 0x80). Used as boot/test loader while the CPU is held off the bus.

---
 rtl/dram_stream_loader_pkg.sv | 21 ++
 rtl/dram_stream_loader_if.sv | 24 ++
 rtl/dram_stream_loader_bus_reg_stage.sv | 37 +++
 rtl/dram_stream_loader.sv | 183 ++++++++++++++++++
 tb/tb_dram_stream_loader.sv | 322 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dram_stream_loader_pkg.sv
// Shared definitions for the DRAM stream loader and the CPU-side I/O decode.
package dram_stream_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_REPORT
  } state_t;

  localparam int unsigned DSL_MAX_WORDS      = 32;
  localparam int unsigned IDX_W              = 5;
  localparam int unsigned LEN_W              = 6;
  localparam logic [31:0] DSL_IO_STATUS_ADDR = 32'h0000_0080;

  // Byte address of a data-memory word; bit 7 stays clear so it never hits I/O.
  function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
    return {24'b0, 1'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/dram_stream_loader_if.sv
// Stream input and memory-stage bus of the loader.
interface dram_stream_loader_if;

  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        mwmem;
  logic [31:0] malu;
  logic [31:0] mb;
  logic [31:0] mmo;

  // Loader side: consumes the stream, initiates bus cycles.
  modport master (
    input  in_valid, in_data, mmo,
    output in_ready, mwmem, malu, mb
  );

  // Environment side: stream source and data memory / I/O target.
  modport slave (
    output in_valid, in_data, mmo,
    input  in_ready, mwmem, malu, mb
  );

endinterface

// File: rtl/dram_stream_loader_bus_reg_stage.sv
// Registered bus outputs; write enable is re-evaluated every cycle,
// address and data only change when explicitly loaded.
module bus_reg_stage (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic        addr_ld_i,
  input  logic [31:0] addr_i,
  input  logic        data_ld_i,
  input  logic [31:0] data_i,
  output logic        mwmem_o,
  output logic [31:0] malu_o,
  output logic [31:0] mb_o
);

  logic        mwmem_q;
  logic [31:0] malu_q;
  logic [31:0] mb_q;

  // Bus registers with async clear so a reset drops any cycle in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mwmem_q <= 1'b0;
      malu_q  <= '0;
      mb_q    <= '0;
    end else begin
      mwmem_q <= we_i;
      if (addr_ld_i) malu_q <= addr_i;
      if (data_ld_i) mb_q   <= data_i;
    end
  end

  assign mwmem_o = mwmem_q;
  assign malu_o  = malu_q;
  assign mb_o    = mb_q;

endmodule

// File: rtl/dram_stream_loader.sv
// Boot/test loader: streams words into data memory, reads them back,
// compares checksums and posts a status word to I/O port 0.
module dram_stream_loader
  import dram_stream_loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS      = DSL_MAX_WORDS,
  parameter logic [31:0] IO_STATUS_ADDR = DSL_IO_STATUS_ADDR
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [LEN_W-1:0]     len,
  dram_stream_loader_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [31:0]          checksum
);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] len_clamp;
  logic [31:0]      wsum_q, wsum_d;
  logic [31:0]      rsum_q, rsum_d;
  logic [31:0]      chk_q, chk_d;
  logic [31:0]      rsum_plus;
  logic             err_q, err_d;
  logic             rd_pend_q, rd_pend_d;
  logic             done_q, done_d;
  logic             in_ready_c;
  logic             hs;
  logic             err_n;

  logic             bus_we;
  logic             bus_addr_ld;
  logic [31:0]      bus_addr;
  logic             bus_data_ld;
  logic [31:0]      bus_data;

  assign len_clamp  = (32'(len) > MAX_WORDS) ? LEN_W'(MAX_WORDS) : len;
  assign in_ready_c = (state_q == ST_LOAD) && (idx_q < len_q);
  assign hs         = bus.in_valid & in_ready_c;
  // The last read is sampled on the same edge that launches the status
  // store, so the comparison must include the word arriving on mmo now.
  assign rsum_plus  = rsum_q + bus.mmo;
  assign err_n      = (wsum_q != rsum_plus);

  // State, counters and checksums.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      len_q     <= '0;
      wsum_q    <= '0;
      rsum_q    <= '0;
      chk_q     <= '0;
      err_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      wsum_q    <= wsum_d;
      rsum_q    <= rsum_d;
      chk_q     <= chk_d;
      err_q     <= err_d;
      rd_pend_q <= rd_pend_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic and bus register loads.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    len_d       = len_q;
    wsum_d      = wsum_q;
    rsum_d      = rsum_q;
    chk_d       = chk_q;
    err_d       = err_q;
    rd_pend_d   = rd_pend_q;
    done_d      = 1'b0;
    bus_we      = 1'b0;
    bus_addr_ld = 1'b0;
    bus_addr    = '0;
    bus_data_ld = 1'b0;
    bus_data    = '0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = len_clamp;
          idx_d     = '0;
          wsum_d    = '0;
          rsum_d    = '0;
          err_d     = 1'b0;
          chk_d     = '0;
          rd_pend_d = 1'b0;
          if (len_clamp == '0) begin
            // Empty job: the status store is launched straight from IDLE.
            state_d     = ST_REPORT;
            bus_we      = 1'b1;
            bus_addr_ld = 1'b1;
            bus_addr    = IO_STATUS_ADDR;
            bus_data_ld = 1'b1;
            bus_data    = '0;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (hs) begin
          bus_we      = 1'b1;
          bus_addr_ld = 1'b1;
          bus_addr    = word_addr(idx_q[IDX_W-1:0]);
          bus_data_ld = 1'b1;
          bus_data    = bus.in_data;
          wsum_d      = wsum_q + bus.in_data;
          idx_d       = idx_q + LEN_W'(1);
          if (idx_q + LEN_W'(1) == len_q) begin
            state_d = ST_VERIFY;
            idx_d   = '0;
          end
        end
      end

      ST_VERIFY: begin
        if (rd_pend_q) rsum_d = rsum_plus;
        if (idx_q < len_q) begin
          bus_addr_ld = 1'b1;
          bus_addr    = word_addr(idx_q[IDX_W-1:0]);
          idx_d       = idx_q + LEN_W'(1);
          rd_pend_d   = 1'b1;
        end else begin
          rd_pend_d   = 1'b0;
          state_d     = ST_REPORT;
          bus_we      = 1'b1;
          bus_addr_ld = 1'b1;
          bus_addr    = IO_STATUS_ADDR;
          bus_data_ld = 1'b1;
          bus_data    = {err_n, 25'b0, len_q};
          err_d       = err_n;
          chk_d       = wsum_q;
        end
      end

      ST_REPORT: begin
        state_d     = ST_IDLE;
        done_d      = 1'b1;
        bus_addr_ld = 1'b1;
        bus_addr    = '0;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  bus_reg_stage u_bus_reg_stage (
    .clk_i     (clock),
    .rst_ni    (resetn),
    .we_i      (bus_we),
    .addr_ld_i (bus_addr_ld),
    .addr_i    (bus_addr),
    .data_ld_i (bus_data_ld),
    .data_i    (bus_data),
    .mwmem_o   (bus.mwmem),
    .malu_o    (bus.malu),
    .mb_o      (bus.mb)
  );

  assign bus.in_ready = in_ready_c;
  assign busy         = (state_q != ST_IDLE);
  assign done         = done_q;
  assign err          = err_q;
  assign checksum     = chk_q;

endmodule

// File: tb/tb_dram_stream_loader.sv
// Bench for dram_stream_loader: job-level timeline model plus DRAM model.
module tb_dram_stream_loader;

  logic        clock;
  logic        resetn;
  logic        start;
  logic [5:0]  len;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;

  dram_stream_loader_if bus ();

  dram_stream_loader dut (
    .clock    (clock),
    .resetn   (resetn),
    .start    (start),
    .len      (len),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .checksum (checksum)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Data memory with an optional read fault on word 1.
  logic [31:0] mem [0:31];
  bit          corrupt;
  always @(posedge clock)
    if (bus.mwmem && !bus.malu[7]) mem[bus.malu[6:2]] <= bus.mb;
  assign bus.mmo = mem[bus.malu[6:2]] ^ ((corrupt && bus.malu[6:2] == 5'd1) ? 32'd1 : 32'd0);

  typedef struct packed {
    bit          we, ready, busy, done, rep, av, mv, err;
    logic [31:0] addr, mb, cks;
  } exp_t;

  exp_t        expq[$];
  int          n_pass, n_checks;
  bit          pend_done, pend_err, held_err;
  logic [31:0] pend_cks, held_cks;
  logic [31:0] last_status, last_cks, last_waddr;
  bit          last_err;
  logic [31:0] jd [0:39];
  bit          vpat [0:5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic exp_t mk(input bit we, input bit rdy, input bit bsy);
    exp_t e;
    e       = '0;
    e.we    = we;
    e.ready = rdy;
    e.busy  = bsy;
    return e;
  endfunction

  task automatic push(input exp_t e_in);
    exp_t e;
    e = e_in;
    if (pend_done) begin
      e.done    = 1'b1;
      held_err  = pend_err;
      held_cks  = pend_cks;
      pend_done = 1'b0;
    end
    e.err = held_err;
    e.cks = held_cks;
    expq.push_back(e);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_step();
    step();
    start        = 1'b0;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_data  = $urandom;
    push(mk(1'b0, 1'b0, 1'b0));
  endtask

  // One complete job as seen on the pins, from the start cycle to REPORT.
  task automatic run_job(input logic [5:0] l_in, input int vmode, input bit stray);
    int          L, acc, lc;
    bit          hs_prev, v, e_bit;
    logic [31:0] wsum, rsum;
    exp_t        e;
    L = (int'(l_in) > 32) ? 32 : int'(l_in);
    step();
    start        = 1'b1;
    len          = l_in;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_data  = $urandom;
    push(mk(1'b0, 1'b0, 1'b0));
    wsum = '0;
    rsum = '0;
    if (L == 0) begin
      step();
      start = 1'b0;
      e = mk(1'b1, 1'b0, 1'b1);
      e.rep = 1'b1; e.av = 1'b1; e.addr = 32'h80; e.mv = 1'b1; e.mb = '0;
      push(e);
      pend_done = 1'b1; pend_err = 1'b0; pend_cks = '0;
      return;
    end
    acc = 0; lc = 0; hs_prev = 1'b0;
    while (acc < L) begin
      step();
      start = 1'b0;
      e = mk(hs_prev, 1'b1, 1'b1);
      if (hs_prev) begin
        e.av = 1'b1; e.addr = 32'(acc * 4 - 4); e.mv = 1'b1; e.mb = jd[acc-1];
      end
      push(e);
      case (vmode)
        0:       v = 1'b1;
        1:       v = ($urandom_range(0, 3) != 0);
        default: v = (lc < 6) ? vpat[lc] : 1'b1;
      endcase
      lc++;
      bus.in_valid = v;
      bus.in_data  = v ? jd[acc] : $urandom;
      if (v) begin
        wsum += jd[acc];
        acc++;
      end
      hs_prev = v;
    end
    // trailing write of the last word
    step();
    e = mk(1'b1, 1'b0, 1'b1);
    e.av = 1'b1; e.addr = 32'(L * 4 - 4); e.mv = 1'b1; e.mb = jd[L-1];
    push(e);
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_data  = $urandom;
    for (int i = 0; i < L; i++) begin
      step();
      start = (stray && i == 1);
      e = mk(1'b0, 1'b0, 1'b1);
      e.av = 1'b1; e.addr = 32'(i * 4);
      push(e);
      rsum += jd[i] ^ ((corrupt && i == 1) ? 32'd1 : 32'd0);
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_data  = $urandom;
    end
    step();
    start = 1'b0;
    e_bit = (wsum != rsum);
    e = mk(1'b1, 1'b0, 1'b1);
    e.rep = 1'b1; e.av = 1'b1; e.addr = 32'h80; e.mv = 1'b1;
    e.mb = {e_bit, 25'b0, 6'(L)};
    push(e);
    pend_done = 1'b1; pend_err = e_bit; pend_cks = wsum;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  // Per-cycle comparison of the pins against the queued timeline.
  always @(negedge clock) begin
    exp_t e;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      chk("mwmem", 32'(bus.mwmem), 32'(e.we));
      chk("in_ready", 32'(bus.in_ready), 32'(e.ready));
      chk("busy", 32'(busy), 32'(e.busy));
      chk("done", 32'(done), 32'(e.done));
      chk("malu_form", {21'b0, bus.malu[31:8], bus.malu[7], bus.malu[1:0]},
          {21'b0, 24'b0, e.rep, 2'b00});
      if (e.av) chk("malu", bus.malu, e.addr);
      if (e.mv) chk("mb", bus.mb, e.mb);
      if (!e.busy) begin
        chk("err", 32'(err), 32'(e.err));
        chk("checksum", checksum, e.cks);
      end
      if (e.rep) last_status = bus.mb;
      if (e.we && !e.rep) last_waddr = bus.malu;
      if (e.done) begin
        last_cks = checksum;
        last_err = err;
      end
    end
  end

  initial begin
    n_pass = 0; n_checks = 0;
    pend_done = 1'b0; held_err = 1'b0; held_cks = '0;
    corrupt = 1'b0;
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    resetn = 1'b0; start = 1'b0; len = '0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mwmem", 32'(bus.mwmem), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_checksum", checksum, 0);
    resetn = 1'b1;
    repeat (2) idle_step();

    // reset in the middle of LOAD, after three accepted words
    for (int i = 0; i < 5; i++) jd[i] = $urandom;
    step();
    start = 1'b1; len = 6'd5; bus.in_valid = 1'b0;
    push(mk(1'b0, 1'b0, 1'b0));
    for (int k = 0; k < 3; k++) begin
      exp_t e;
      step();
      start = 1'b0;
      e = mk(k > 0, 1'b1, 1'b1);
      if (k > 0) begin
        e.av = 1'b1; e.addr = 32'(k * 4 - 4); e.mv = 1'b1; e.mb = jd[k-1];
      end
      push(e);
      bus.in_valid = 1'b1; bus.in_data = jd[k];
    end
    begin
      exp_t e;
      step();
      e = mk(1'b1, 1'b1, 1'b1);
      e.av = 1'b1; e.addr = 32'h8; e.mv = 1'b1; e.mb = jd[2];
      push(e);
      bus.in_valid = 1'b1; bus.in_data = jd[3];
    end
    #6;
    resetn = 1'b0;
    #1;
    chk("arst_mwmem", 32'(bus.mwmem), 0);
    chk("arst_malu", bus.malu, 0);
    chk("arst_mb", bus.mb, 0);
    chk("arst_in_ready", 32'(bus.in_ready), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_checksum", checksum, 0);
    bus.in_valid = 1'b0;
    held_err = 1'b0; held_cks = '0; pend_done = 1'b0;
    repeat (2) begin
      step();
      push(mk(1'b0, 1'b0, 1'b0));
    end
    resetn = 1'b1;
    repeat (3) idle_step();

    // len=4, words 1..4 back to back
    for (int i = 0; i < 4; i++) jd[i] = 32'(i + 1);
    run_job(6'd4, 0, 1'b0);
    idle_step();
    settle();
    chk("pin_status_len4", last_status, 32'h0000_0004);
    chk("pin_cks_len4", last_cks, 32'd10);
    chk("pin_err_len4", 32'(last_err), 0);

    // len=3 with in_valid pattern 1,0,0,1,0,1
    for (int i = 0; i < 3; i++) jd[i] = $urandom;
    run_job(6'd3, 2, 1'b0);
    idle_step();

    // read-back fault on word 1
    corrupt = 1'b1;
    for (int i = 0; i < 3; i++) jd[i] = $urandom;
    run_job(6'd3, 1, 1'b0);
    idle_step();
    settle();
    chk("pin_status_corrupt", last_status, 32'h8000_0003);
    chk("pin_err_corrupt", 32'(last_err), 1);
    corrupt = 1'b0;

    // empty job
    run_job(6'd0, 0, 1'b0);
    idle_step();
    settle();
    chk("pin_status_len0", last_status, 32'h0);
    chk("pin_cks_len0", last_cks, 32'h0);

    // length clamp
    for (int i = 0; i < 40; i++) jd[i] = $urandom;
    run_job(6'd40, 1, 1'b0);
    idle_step();
    settle();
    chk("pin_status_len40", last_status, 32'h0000_0020);
    chk("pin_last_waddr_len40", last_waddr, 32'h0000_007C);

    // checksum wrap, with a stray start during VERIFY
    jd[0] = 32'hFFFF_FFFF; jd[1] = 32'h0000_0002;
    run_job(6'd2, 0, 1'b1);
    idle_step();
    settle();
    chk("pin_cks_wrap", last_cks, 32'h1);
    chk("pin_err_wrap", 32'(last_err), 0);

    // random jobs, some launched in the done cycle of the previous one
    for (int j = 0; j < 8; j++) begin
      logic [5:0] l;
      l = 6'($urandom_range(0, 40));
      for (int i = 0; i < 40; i++) jd[i] = $urandom;
      corrupt = ($urandom_range(0, 3) == 0);
      run_job(l, 1, ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 1) == 1) idle_step();
    end
    repeat (3) idle_step();
    settle();
    chk("queue_drained", 32'(expq.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
